// File: rtl/spi_master.sv
// SPI mode-0 master: 24-bit write frames (opcode byte first) and 16-bit read frames.
// A frame is followed by a fixed gap with SPI_SS high before the next command is accepted.
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [23:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  // state    | meaning
  // IDLE     | waiting for a command, SS high
  // SHIFT_LO | SCK low half-period, MOSI holds current bit
  // SHIFT_HI | SCK high half-period, MISO sampled on entry
  // TAIL     | SS held low one half-period after the last SCK fall
  // GAP      | SS high, inter-frame spacing
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, TAIL, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmr, tmr_nxt;
  logic [4:0]  bits, bits_nxt;
  logic [23:0] tx_sr, tx_sr_nxt, tx_load;
  logic [15:0] rx_sr, rx_sr_nxt, rsp_data_nxt;
  logic        is_read, is_read_nxt;
  logic        sck_nxt, ss_nxt, mosi_nxt, rsp_valid_nxt;
  logic        tmr_done;

  assign tmr_done  = (tmr == 8'd0);
  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= 8'd0;
      bits      <= 5'd0;
      tx_sr     <= 24'd0;
      rx_sr     <= 16'd0;
      is_read   <= 1'b0;
      SPI_SCK   <= 1'b0;
      SPI_SS    <= 1'b1;
      SPI_MOSI  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      bits      <= bits_nxt;
      tx_sr     <= tx_sr_nxt;
      rx_sr     <= rx_sr_nxt;
      is_read   <= is_read_nxt;
      SPI_SCK   <= sck_nxt;
      SPI_SS    <= ss_nxt;
      SPI_MOSI  <= mosi_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tmr_nxt       = tmr_done ? tmr : tmr - 8'd1;
    bits_nxt      = bits;
    tx_sr_nxt     = tx_sr;
    rx_sr_nxt     = rx_sr;
    is_read_nxt   = is_read;
    sck_nxt       = SPI_SCK;
    ss_nxt        = SPI_SS;
    mosi_nxt      = SPI_MOSI;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    // Bytes go out low byte first, so reorder them once and shift MSB-first.
    tx_load = cmd_read ? 24'd0 : {cmd_data[7:0], cmd_data[15:8], cmd_data[23:16]};

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt   = SHIFT_LO;
          tmr_nxt     = DIV_LOAD;
          bits_nxt    = cmd_read ? 5'd15 : 5'd23;
          tx_sr_nxt   = tx_load;
          rx_sr_nxt   = 16'd0;
          is_read_nxt = cmd_read;
          ss_nxt      = 1'b0;
          sck_nxt     = 1'b0;
          mosi_nxt    = tx_load[23];
        end
      end
      SHIFT_LO: begin
        if (tmr_done) begin
          state_nxt = SHIFT_HI;
          tmr_nxt   = DIV_LOAD;
          sck_nxt   = 1'b1;
          rx_sr_nxt = {rx_sr[14:0], SPI_MISO};
        end
      end
      SHIFT_HI: begin
        if (tmr_done) begin
          tmr_nxt = DIV_LOAD;
          sck_nxt = 1'b0;
          if (bits == 5'd0) begin
            state_nxt = TAIL;
          end else begin
            state_nxt = SHIFT_LO;
            bits_nxt  = bits - 5'd1;
            tx_sr_nxt = {tx_sr[22:0], 1'b0};
            mosi_nxt  = tx_sr[22];
          end
        end
      end
      TAIL: begin
        if (tmr_done) begin
          state_nxt = GAP;
          tmr_nxt   = GAP_LOAD;
          ss_nxt    = 1'b1;
          mosi_nxt  = 1'b0;
          if (is_read) begin
            // First received byte was shifted in first, so it sits in the upper half.
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = {rx_sr[7:0], rx_sr[15:8]};
          end
        end
      end
      GAP: begin
        if (tmr_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: two masters (fast and slow divider), a MISO slave model and a line monitor
// that measures frames at the SPI pins; tasks compare against values derived from the frame rules.
module tb_spi_master;
  localparam int DIV_A = 2;
  localparam int DIV_B = 255;
  localparam int GAP   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_a, cmd_valid_b, cmd_read;
  logic [23:0] cmd_data;
  logic        rdy_a, rdy_b, rsp_valid_a, rsp_valid_b, busy_a, busy_b;
  logic        sck_a, sck_b, ss_a, ss_b, mosi_a, mosi_b;
  logic [15:0] rsp_data_a, rsp_data_b;
  logic [1:0]  miso_v, sck_v, ss_v, mosi_v, rsp_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(rdy_a), .cmd_read(cmd_read),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
    .SPI_SCK(sck_a), .SPI_SS(ss_a), .SPI_MOSI(mosi_a), .SPI_MISO(miso_v[0]));

  spi_master #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(rdy_b), .cmd_read(cmd_read),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
    .SPI_SCK(sck_b), .SPI_SS(ss_b), .SPI_MOSI(mosi_b), .SPI_MISO(miso_v[1]));

  assign sck_v  = {sck_b, sck_a};
  assign ss_v   = {ss_b, ss_a};
  assign mosi_v = {mosi_b, mosi_a};
  assign rsp_v  = {rsp_valid_b, rsp_valid_a};

  // Monitor / slave state, one slot per master
  int          rises[2], last_rises[2], frames[2], low_len[2], last_low[2];
  int          gap_len[2], last_gap[2], run[2], falls[2];
  int          hp_bad[2], sck_ss_bad[2], rsp_cnt[2], rsp_long[2], rsp_mis[2];
  logic [23:0] mosi_sr[2], last_mosi[2];
  logic [15:0] slave_val[2];
  logic        prev_sck[2], prev_ss[2], prev_rsp[2];
  logic [7:0]  mon_byte;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        prev_ss[i] = 1'b1; prev_sck[i] = 1'b0; prev_rsp[i] = 1'b0;
        falls[i] = 0; rises[i] = 0; gap_len[i] = 0; miso_v[i] = 1'b0;
      end else begin
        if (ss_v[i] && sck_v[i]) sck_ss_bad[i]++;
        if (rsp_v[i]) begin
          rsp_cnt[i]++;
          if (prev_rsp[i]) rsp_long[i]++;
          if (!(ss_v[i] && !prev_ss[i])) rsp_mis[i]++;
        end
        if (!ss_v[i]) begin
          if (prev_ss[i]) begin
            last_gap[i] = gap_len[i]; low_len[i] = 1; rises[i] = 0; falls[i] = 0;
            mosi_sr[i] = 24'd0; run[i] = 1;
          end else begin
            low_len[i]++;
            if (sck_v[i] == prev_sck[i]) run[i]++;
            else begin
              if (run[i] != ((i == 0) ? DIV_A : DIV_B)) hp_bad[i]++;
              run[i] = 1;
            end
            if (sck_v[i] && !prev_sck[i]) begin
              rises[i]++;
              mosi_sr[i] = {mosi_sr[i][22:0], mosi_v[i]};
            end
            if (!sck_v[i] && prev_sck[i]) falls[i]++;
          end
        end else begin
          if (!prev_ss[i]) begin
            if (run[i] != ((i == 0) ? DIV_A : DIV_B)) hp_bad[i]++;
            last_low[i] = low_len[i]; last_rises[i] = rises[i]; last_mosi[i] = mosi_sr[i];
            frames[i]++; gap_len[i] = 1;
          end else gap_len[i]++;
          falls[i] = 0;
        end
        // Slave presents bit k after the k-th SCK fall: low byte first, MSB first.
        if (!ss_v[i] && falls[i] < 16) begin
          mon_byte = (falls[i] < 8) ? slave_val[i][7:0] : slave_val[i][15:8];
          miso_v[i] = mon_byte[7 - (falls[i] % 8)];
        end else miso_v[i] = 1'b0;
        prev_ss[i] = ss_v[i]; prev_sck[i] = sck_v[i]; prev_rsp[i] = rsp_v[i];
      end
    end
  end

  function automatic logic [23:0] wire_order(input logic [23:0] d);
    logic [23:0] r = 24'd0;
    for (int b = 0; b < 3; b++) r = (r << 8) | ((d >> (8 * b)) & 24'hFF);
    return r;
  endfunction

  task automatic wait_frames(input int i, input int target, input int limit);
    int n = 0;
    while (frames[i] < target && n < limit) begin @(posedge clk); #1; n++; end
    if (frames[i] < target) begin
      checks++; errors++;
      $display("FAIL frame_timeout inst=%0d: frames=%0d required=%0d", i, frames[i], target);
    end
  endtask

  task automatic send(input int i, input bit rd, input logic [23:0] d);
    int n = 0;
    cmd_read = rd; cmd_data = d;
    while (!((i == 0) ? rdy_a : rdy_b) && n < 20000) begin @(posedge clk); #1; n++; end
    if (i == 0) cmd_valid_a = 1'b1; else cmd_valid_b = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
  endtask

  task automatic run_frame(input int i, input bit rd, input logic [23:0] d, input logic [15:0] v,
                           input string tag);
    int base = frames[i];
    int rc = rsp_cnt[i];
    int nb = rd ? 16 : 24;
    int div = (i == 0) ? DIV_A : DIV_B;
    logic [23:0] exp_m = rd ? 24'd0 : wire_order(d);
    logic [15:0] got_rsp;
    slave_val[i] = v;
    send(i, rd, d);
    wait_frames(i, base + 1, (2 * nb + 1) * div + 50);
    got_rsp = (i == 0) ? rsp_data_a : rsp_data_b;
    checks++;
    if (last_rises[i] !== nb) begin errors++;
      $display("FAIL %s sck_rises: got %0d required %0d", tag, last_rises[i], nb); end
    checks++;
    if (last_mosi[i] !== exp_m) begin errors++;
      $display("FAIL %s mosi_bits: got %06h required %06h", tag, last_mosi[i], exp_m); end
    checks++;
    if (last_low[i] !== (2 * nb + 1) * div) begin errors++;
      $display("FAIL %s ss_low_len: got %0d required %0d", tag, last_low[i], (2 * nb + 1) * div); end
    checks++;
    if (rsp_cnt[i] !== rc + (rd ? 1 : 0)) begin errors++;
      $display("FAIL %s rsp_pulses: got %0d required %0d", tag, rsp_cnt[i] - rc, rd ? 1 : 0); end
    if (rd) begin
      checks++;
      if (got_rsp !== v) begin errors++;
        $display("FAIL %s rsp_data: got %04h required %04h", tag, got_rsp, v); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_read = 1'b0; cmd_data = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ss_a, sck_a, mosi_a, rdy_a, busy_a, rsp_valid_a} !== 6'b100000) begin errors++;
      $display("FAIL reset_pins: got %06b required 100000", {ss_a, sck_a, mosi_a, rdy_a, busy_a, rsp_valid_a}); end
    checks++;
    if (rsp_data_a !== 16'd0) begin errors++;
      $display("FAIL reset_rsp_data: got %04h required 0000", rsp_data_a); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin errors++;
      $display("FAIL reset_release: ready=%b busy=%b required ready=1 busy=0", rdy_a, busy_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_fixed();
    run_frame(0, 1'b0, 24'h00AB02, 16'hFFFF, "write_00AB02");
  endtask

  task automatic test_read_fixed();
    run_frame(0, 1'b1, 24'hFFFFFF, 16'h1234, "read_1234");
  endtask

  task automatic test_reset_midframe();
    int rc = rsp_cnt[0];
    int n = 0;
    logic [15:0] v = 16'($urandom);
    slave_val[0] = 16'hBEEF;
    send(0, 1'b1, 24'd0);
    while (rises[0] < 10 && n < 200) begin @(posedge clk); #1; n++; end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ss_a, sck_a, mosi_a, busy_a, rdy_a, rsp_valid_a} !== 6'b100000) begin errors++;
      $display("FAIL abort_pins: got %06b required 100000", {ss_a, sck_a, mosi_a, busy_a, rdy_a, rsp_valid_a}); end
    checks++;
    if (rsp_data_a !== 16'd0) begin errors++;
      $display("FAIL abort_rsp_data: got %04h required 0000", rsp_data_a); end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b1) begin errors++;
      $display("FAIL abort_ready: got %b required 1", rdy_a); end
    checks++;
    if (rsp_cnt[0] !== rc) begin errors++;
      $display("FAIL abort_rsp_pulse: got %0d pulses required 0", rsp_cnt[0] - rc); end
    run_frame(0, 1'b1, 24'd0, v, "read_after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_frame(0, 1'($urandom), 24'($urandom), 16'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int base = frames[0];
    int n = 0;
    logic [23:0] m1;
    logic [15:0] v = 16'($urandom);
    cmd_read = 1'b0; cmd_data = 24'h000004; cmd_valid_a = 1'b1;
    while (!rdy_a && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_read = 1'b1; cmd_data = 24'($urandom); slave_val[0] = v;
    n = 0;
    while (!rdy_a && n < 200) begin @(posedge clk); #1; n++; end
    m1 = last_mosi[0];
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
    wait_frames(0, base + 2, 200);
    checks++;
    if (m1 !== 24'h040000) begin errors++;
      $display("FAIL b2b_first_mosi: got %06h required 040000", m1); end
    checks++;
    if (last_gap[0] !== GAP + 1) begin errors++;
      $display("FAIL b2b_gap: got %0d required %0d", last_gap[0], GAP + 1); end
    checks++;
    if (last_rises[0] !== 16 || rsp_data_a !== v) begin errors++;
      $display("FAIL b2b_second_read: rises=%0d rsp=%04h required 16/%04h", last_rises[0], rsp_data_a, v); end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (frames[0] !== base + 2) begin errors++;
      $display("FAIL b2b_frame_count: got %0d required %0d", frames[0] - base, 2); end
  endtask

  task automatic test_busy_ignore();
    int base = frames[0];
    int rc = rsp_cnt[0];
    int bad = 0;
    int n = 0;
    logic [23:0] d = 24'($urandom);
    slave_val[0] = 16'h5A5A;
    send(0, 1'b0, d);
    while (busy_a && n < 500) begin
      cmd_valid_a = 1'b1; cmd_data = 24'($urandom); cmd_read = 1'($urandom);
      if (rdy_a) bad++;
      @(posedge clk); #1; n++;
    end
    cmd_valid_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n >= 500) begin errors++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy_a, n); end
    checks++;
    if (bad !== 0) begin errors++;
      $display("FAIL busy_ready_low: ready high %0d cycles required 0", bad); end
    checks++;
    if (frames[0] !== base + 1) begin errors++;
      $display("FAIL busy_frame_count: got %0d required 1", frames[0] - base); end
    checks++;
    if (last_mosi[0] !== wire_order(d) || last_rises[0] !== 24) begin errors++;
      $display("FAIL busy_payload: got %06h/%0d required %06h/24", last_mosi[0], last_rises[0], wire_order(d)); end
    checks++;
    if (rsp_cnt[0] !== rc) begin errors++;
      $display("FAIL busy_rsp_pulse: got %0d required 0", rsp_cnt[0] - rc); end
  endtask

  task automatic test_slow();
    run_frame(1, 1'b0, 24'($urandom), 16'd0, "slow_write");
    run_frame(1, 1'b1, 24'd0, 16'($urandom), "slow_read");
  endtask

  task automatic test_invariants();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hp_bad[i] !== 0) begin errors++;
        $display("FAIL half_period inst=%0d: got %0d bad runs required 0", i, hp_bad[i]); end
      checks++;
      if (sck_ss_bad[i] !== 0) begin errors++;
        $display("FAIL sck_with_ss_high inst=%0d: got %0d cycles required 0", i, sck_ss_bad[i]); end
      checks++;
      if (rsp_long[i] !== 0 || rsp_mis[i] !== 0) begin errors++;
        $display("FAIL rsp_pulse_shape inst=%0d: long=%0d misaligned=%0d required 0/0", i, rsp_long[i], rsp_mis[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_fixed();
    test_read_fixed();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_slow();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, number of clk cycles per SPI_SCK half-period; legal range 2..255.
REQ-002 Parameter GAP_CYCLES, default 4, number of clk cycles SPI_SS stays high between consecutive frames; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  a command is presented on cmd_read/cmd_data.
REQ-006 cmd_ready  output  1  the block accepts a command this cycle.
REQ-007 cmd_read  input  1  frame type: 0 = 24-bit write frame, 1 = 16-bit read frame.
REQ-008 cmd_data  input  24  write-frame payload; [7:0] opcode, [23:8] argument; ignored for read frames.
REQ-009 rsp_valid  output  1  one-cycle pulse; rsp_data holds the completed read-frame result.
REQ-010 rsp_data  output  16  last read-frame result; holds its value until the next read frame completes.
REQ-011 busy  output  1  a frame or inter-frame gap is in progress.
REQ-012 SPI_SCK  output  1  serial clock, idle low (mode 0).
REQ-013 SPI_SS  output  1  active-low slave select.
REQ-014 SPI_MOSI  output  1  serial data to slave.
REQ-015 SPI_MISO  input  1  serial data from slave.

Function
REQ-016 The block SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, TAIL and GAP.
REQ-017 In IDLE, cmd_ready SHALL be 1 and busy SHALL be 0; in every other state, cmd_ready SHALL be 0 and busy SHALL be 1.
REQ-018 A command SHALL be accepted on the clk edge where cmd_valid and cmd_ready are both 1.
  - Next cycle: SPI_SS = 0, SPI_MOSI = first bit, state = SHIFT_LO.
REQ-019 A write frame SHALL shift 24 bits in byte order cmd_data[7:0], cmd_data[15:8], cmd_data[23:16], each byte MSB first.
REQ-020 A read frame SHALL shift 16 bits with SPI_MOSI held 0.
  - The first received byte SHALL go to rsp_data[7:0] and the second to rsp_data[15:8], each byte MSB first.
REQ-021 SHIFT_LO SHALL last CLK_DIV cycles with SPI_SCK = 0; it then SHALL enter SHIFT_HI with SPI_SCK = 1 and sample SPI_MISO on that same edge.
REQ-022 SHIFT_HI SHALL last CLK_DIV cycles; then:
  - Bits remaining: return to SHIFT_LO with SPI_SCK = 0, and update SPI_MOSI to the next bit on the same edge.
  - Last bit done: enter TAIL with SPI_SCK = 0.
REQ-023 TAIL SHALL last CLK_DIV cycles with SPI_SS = 0; it then SHALL set SPI_SS = 1, SPI_MOSI = 0 and enter GAP.
REQ-024 For read frames, rsp_data SHALL update and rsp_valid SHALL pulse for exactly one cycle on the edge where SPI_SS returns high.
  - Write frames SHALL never assert rsp_valid.
REQ-025 GAP SHALL last GAP_CYCLES cycles and then enter IDLE.
  - Total SPI_SS-low time SHALL be (2*N+1)*CLK_DIV cycles, N = 24 or 16.
REQ-026 Exactly N rising SPI_SCK edges SHALL occur per frame; SPI_SCK SHALL never be high while SPI_SS is high.
REQ-027 cmd_valid while busy SHALL be ignored and SHALL NOT be queued; cmd_data/cmd_read changes after acceptance SHALL NOT affect the frame in flight.
REQ-028 Back-to-back cmd_valid SHALL be served with exactly GAP_CYCLES+1 cycles from SPI_SS rising to SPI_SS falling.

Reset
REQ-029 While reset is 1, asynchronously and regardless of clk:
  - SPI_SS = 1; SPI_SCK = 0; SPI_MOSI = 0.
  - cmd_ready = 0; busy = 0; rsp_valid = 0; rsp_data = 0.
  - State = IDLE.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rsp_valid pulse; cmd_ready SHALL be 1 on the first clk edge after reset deasserts.

Verification
REQ-031 CLK_DIV=2: write 24'h00AB02 -> 24 SCK pulses; MOSI bytes 0x02, 0xAB, 0x00 (MSB first); SS low 98 cycles; no rsp_valid.
REQ-032 CLK_DIV=2: read, MISO model drives 0x34 then 0x12 -> 16 SCK pulses, MOSI all 0, rsp_data = 16'h1234, rsp_valid one cycle at SS rise.
REQ-033 Continuous cmd_valid, write 24'h000004 then read, GAP_CYCLES=4 -> SS high exactly 5 cycles between frames; second frame bits correct.
REQ-034 cmd_valid pulsed at every cycle of a frame in flight -> no extra frame, cmd_data changes have no effect, cmd_ready low throughout.
REQ-035 Reset asserted after 10 SCK pulses of a read frame -> SS=1, SCK=0 immediately; no rsp_valid; rsp_data = 0; a new read after release completes normally.
REQ-036 CLK_DIV=255 and CLK_DIV=2 sweep with a scoreboard -> SCK high/low half-periods equal CLK_DIV for every bit; SCK never high with SS high.
